// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and the alignment rule that decides whether a request may touch memory.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } lsu_state_e;

  // Halves need an even offset, words a zero offset; size 11 never maps to an access.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] offset);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = offset[0];
      SZ_WORD: f = (offset != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Big-endian lane steering: extracts and extends a sub-word load and merges
// sub-word store data into a previously read word.
module byte_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        signed_load,
  input  logic [31:0] st_data,
  output logic [31:0] ld_value,
  output logic [31:0] st_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Offset 0 is the most significant lane, so the bit position is (3 - offset) * 8.
  assign byte_sh = {~offset, 3'b000};
  assign half_sh = {~offset[1], 4'b0000};
  assign ld_byte = word[byte_sh +: 8];
  assign ld_half = word[half_sh +: 16];

  always_comb begin
    ld_value = word;
    st_word  = word;
    case (size)
      SZ_BYTE: begin
        ld_value = signed_load ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
        st_word[byte_sh +: 8] = st_data[7:0];
      end
      SZ_HALF: begin
        ld_value = signed_load ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
        st_word[half_sh +: 16] = st_data[15:0];
      end
      SZ_WORD: begin
        ld_value = word;
        st_word  = st_data;
      end
      default: begin
        ld_value = word;
        st_word  = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequencer between the multi-cycle datapath and the word-addressed data
// memory: byte/half/word loads and stores, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              reqWrite,
  input  logic [1:0]        size,
  input  logic              signedLoad,
  input  logic [ADDR_W+1:0] byteAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] rdData,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataOut,
  input  logic [DATA_W-1:0] memDataIn,
  output lsu_state_e        dbg_state
);

  // Handshake: req is sampled only while busy=0 (IDLE); a req seen while busy is
  // dropped, never queued. Each accepted req yields exactly one done pulse, and
  // fault is meaningful only in that done cycle.

  lsu_state_e        state_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] rd_q;
  logic              fault_q;

  logic [DATA_W-1:0] mux_word;
  logic [DATA_W-1:0] ld_value;
  logic [DATA_W-1:0] st_word;

  // A load extracts straight from memDataIn in READ; stores merge into the buffered word.
  assign mux_word = (state_q == ST_READ) ? memDataIn : buf_q;

  byte_lane_mux u_lane_mux (
    .word        (mux_word),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .signed_load (signed_q),
    .st_data     (wdata_q),
    .ld_value    (ld_value),
    .st_word     (st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      rd_q     <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            write_q  <= reqWrite;
            size_q   <= size;
            signed_q <= signedLoad;
            addr_q   <= byteAddr;
            wdata_q  <= wrData;
            fault_q  <= access_fault(size, byteAddr[1:0]);
            if (access_fault(size, byteAddr[1:0]))
              state_q <= ST_DONE;
            else if (!reqWrite || size != SZ_WORD)
              state_q <= ST_READ;
            else
              state_q <= ST_WRITE;
          end
        end
        ST_READ: begin
          buf_q <= memDataIn;
          if (write_q) begin
            state_q <= ST_WRITE;
          end else begin
            rd_q    <= ld_value;
            state_q <= ST_DONE;
          end
        end
        ST_WRITE: state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode from state alone, so an asynchronous reset drops them at once.
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign fault      = done && fault_q;
  assign rdData     = rd_q;
  assign memRead    = (state_q == ST_READ);
  assign memWrite   = (state_q == ST_WRITE);
  assign memAddr    = (state_q == ST_IDLE) ? '0 : addr_q[ADDR_W+1:2];
  assign memDataOut = (state_q == ST_WRITE) ? st_word : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-word memory model answers the memory port,
// directed scenarios cover the documented cases, and random traffic is checked
// against a byte-array reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic        reqWrite = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        signedLoad = 1'b0;
  logic [6:0]  byteAddr = '0;
  logic [31:0] wrData = '0;
  logic        busy, done, fault, memRead, memWrite;
  logic [31:0] rdData, memDataOut, memDataIn;
  logic [4:0]  memAddr;
  lsu_state_e  dbg_state;

  load_store_unit #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .reqWrite(reqWrite), .size(size),
    .signedLoad(signedLoad), .byteAddr(byteAddr), .wrData(wrData),
    .busy(busy), .done(done), .fault(fault), .rdData(rdData),
    .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
    .memDataOut(memDataOut), .memDataIn(memDataIn), .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign memDataIn = memRead ? mem[memAddr] : 32'h0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (memWrite) mem[memAddr] <= memDataOut;
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [32];
  logic [31:0] ref_rd = 32'h0;
  logic [31:0] exp_q [$];

  // Reference: returns expected latency/strobe counts/fault and the resulting
  // word (new rdData for loads, new memory word for stores), updating the model.
  function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [6:0] a, input logic [31:0] d,
                                output int e_lat, output int e_rd, output int e_wr,
                                output logic e_flt, output logic [31:0] e_word);
    logic [7:0]  b [4];
    logic [31:0] v;
    int off, idx, n;
    off = int'(a[1:0]);
    idx = int'(a[6:2]);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e_flt = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    if (e_flt) begin
      e_lat = 1; e_rd = 0; e_wr = 0; e_word = ref_rd;
      return;
    end
    for (int i = 0; i < 4; i++) b[i] = 8'(ref_mem[idx] >> (24 - 8 * i));
    if (!w) begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(b[off + i]);
      if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      ref_rd = v;
      e_word = v; e_lat = 2; e_rd = 1; e_wr = 0;
    end else begin
      if (n == 4) v = d;
      else begin
        for (int i = 0; i < n; i++) b[off + i] = 8'(d >> (8 * (n - 1 - i)));
        v = {b[0], b[1], b[2], b[3]};
      end
      ref_mem[idx] = v;
      e_word = v; e_lat = (n == 4) ? 2 : 3; e_rd = (n == 4) ? 0 : 1; e_wr = 1;
    end
  endfunction

  // ---------------- driver ----------------
  // Issues one request and watches the bus until done (bounded). lat=0 means timeout.
  task automatic run_access(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [6:0] a, input logic [31:0] d,
                            output int lat, output int n_rd, output int n_wr,
                            output logic [31:0] wr_word, output logic [4:0] acc_addr,
                            output logic flt, output logic overlap);
    @(negedge clk);
    req = 1'b1; reqWrite = w; size = sz; signedLoad = sg; byteAddr = a; wrData = d;
    @(posedge clk);
    lat = 0; n_rd = 0; n_wr = 0; wr_word = 0; acc_addr = 0; flt = 0; overlap = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (memRead) begin n_rd++; acc_addr = memAddr; end
      if (memWrite) begin n_wr++; wr_word = memDataOut; acc_addr = memAddr; end
      if (memRead && memWrite) overlap = 1'b1;
      if (done) begin lat = k; flt = fault; break; end
      @(posedge clk);
    end
    req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      v = (i == 3) ? 32'h8123_45F6 : $urandom;
      pre_we = 1'b1; pre_addr = 5'(i); pre_data = v; ref_mem[i] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;
    checks++;
    if ({busy, done, fault, memRead, memWrite, memAddr, rdData, memDataOut} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b fault=%0b rd=%0b wr=%0b addr=%0d rdData=%h dout=%h, required all 0",
               busy, done, fault, memRead, memWrite, memAddr, rdData, memDataOut);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_rd = 32'h0;
  endtask

  task automatic test_word_load();
    int lat, n_rd, n_wr, e_lat, e_rd, e_wr;
    logic [31:0] ww, ew;
    logic [4:0] aa;
    logic flt, ov, ef;
    model(1'b0, SZ_WORD, 1'b0, 7'd12, 32'h0, e_lat, e_rd, e_wr, ef, ew);
    run_access(1'b0, SZ_WORD, 1'b0, 7'd12, 32'h0, lat, n_rd, n_wr, ww, aa, flt, ov);
    checks++;
    if (lat !== 2 || n_rd !== 1 || n_wr !== 0 || aa !== 5'd3 || flt !== 1'b0) begin
      failures++;
      $display("FAIL word_load_timing: lat=%0d rd=%0d wr=%0d addr=%0d fault=%0b, required 2 1 0 3 0",
               lat, n_rd, n_wr, aa, flt);
    end
    checks++;
    if (rdData !== 32'h8123_45F6) begin
      failures++;
      $display("FAIL word_load_data: got %h required 812345f6", rdData);
    end
  endtask

  task automatic test_subword_loads();
    logic [1:0]  t_sz [4] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF};
    logic        t_sg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0]  t_a  [4] = '{7'd12, 7'd15, 7'd14, 7'd12};
    int lat, n_rd, n_wr, e_lat, e_rd, e_wr;
    logic [31:0] ww, ew;
    logic [4:0] aa;
    logic flt, ov, ef;
    exp_q = '{32'hFFFF_FF81, 32'h0000_00F6, 32'h0000_45F6, 32'hFFFF_8123};
    for (int i = 0; i < 4; i++) begin
      model(1'b0, t_sz[i], t_sg[i], t_a[i], 32'h0, e_lat, e_rd, e_wr, ef, ew);
      run_access(1'b0, t_sz[i], t_sg[i], t_a[i], 32'h0, lat, n_rd, n_wr, ww, aa, flt, ov);
      ew = exp_q.pop_front();
      checks++;
      if (rdData !== ew || lat !== 2 || flt !== 1'b0) begin
        failures++;
        $display("FAIL subword_load_%0d: rdData=%h lat=%0d fault=%0b, required %h 2 0",
                 i, rdData, lat, flt, ew);
      end
    end
  endtask

  task automatic test_byte_store();
    int lat, n_rd, n_wr, e_lat, e_rd, e_wr;
    logic [31:0] ww, ew;
    logic [4:0] aa;
    logic flt, ov, ef;
    model(1'b1, SZ_BYTE, 1'b0, 7'd13, 32'h0000_00AB, e_lat, e_rd, e_wr, ef, ew);
    run_access(1'b1, SZ_BYTE, 1'b0, 7'd13, 32'h0000_00AB, lat, n_rd, n_wr, ww, aa, flt, ov);
    checks++;
    if (lat !== 3 || n_rd !== 1 || n_wr !== 1 || ov !== 1'b0 || aa !== 5'd3) begin
      failures++;
      $display("FAIL byte_store_timing: lat=%0d rd=%0d wr=%0d overlap=%0b addr=%0d, required 3 1 1 0 3",
               lat, n_rd, n_wr, ov, aa);
    end
    checks++;
    if (ww !== 32'h81AB_45F6 || mem[3] !== 32'h81AB_45F6) begin
      failures++;
      $display("FAIL byte_store_data: dout=%h mem3=%h required 81ab45f6", ww, mem[3]);
    end
    model(1'b0, SZ_WORD, 1'b0, 7'd12, 32'h0, e_lat, e_rd, e_wr, ef, ew);
    run_access(1'b0, SZ_WORD, 1'b0, 7'd12, 32'h0, lat, n_rd, n_wr, ww, aa, flt, ov);
    checks++;
    if (rdData !== 32'h81AB_45F6) begin
      failures++;
      $display("FAIL store_readback: got %h required 81ab45f6", rdData);
    end
  endtask

  task automatic test_faults();
    logic [1:0] t_sz [3] = '{SZ_WORD, 2'b11, SZ_HALF};
    logic       t_w  [3] = '{1'b0, 1'b0, 1'b1};
    logic [6:0] t_a  [3] = '{7'd14, 7'd12, 7'd13};
    int lat, n_rd, n_wr, e_lat, e_rd, e_wr;
    logic [31:0] ww, ew, prev_rd, prev_m;
    logic [4:0] aa;
    logic flt, ov, ef;
    for (int i = 0; i < 3; i++) begin
      prev_rd = ref_rd;
      prev_m  = ref_mem[3];
      model(t_w[i], t_sz[i], 1'b1, t_a[i], 32'h5555_AAAA, e_lat, e_rd, e_wr, ef, ew);
      run_access(t_w[i], t_sz[i], 1'b1, t_a[i], 32'h5555_AAAA, lat, n_rd, n_wr, ww, aa, flt, ov);
      checks++;
      if (lat !== 1 || flt !== 1'b1 || n_rd !== 0 || n_wr !== 0) begin
        failures++;
        $display("FAIL fault_%0d: lat=%0d fault=%0b rd=%0d wr=%0d, required 1 1 0 0",
                 i, lat, flt, n_rd, n_wr);
      end
      checks++;
      if (rdData !== prev_rd || mem[3] !== prev_m) begin
        failures++;
        $display("FAIL fault_%0d_side_effect: rdData=%h mem3=%h, required %h %h",
                 i, rdData, mem[3], prev_rd, prev_m);
      end
    end
  endtask

  task automatic test_req_while_busy();
    int n_done, e_lat, e_rd, e_wr;
    logic [31:0] ew;
    logic ef;
    model(1'b0, SZ_WORD, 1'b0, 7'd8, 32'h0, e_lat, e_rd, e_wr, ef, ew);
    n_done = 0;
    @(negedge clk);
    req = 1'b1; reqWrite = 1'b0; size = SZ_WORD; signedLoad = 1'b0; byteAddr = 7'd8;
    @(posedge clk);
    @(negedge clk);
    // Still requesting while in READ, with a different (store) request on the inputs.
    reqWrite = 1'b1; byteAddr = 7'd20;
    checks++;
    if (memRead !== 1'b1) begin
      failures++;
      $display("FAIL busy_req_read: memRead=%0b required 1", memRead);
    end
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) req = 1'b0;
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 1 || busy !== 1'b0 || rdData !== ref_rd) begin
      failures++;
      $display("FAIL busy_req_ignored: dones=%0d busy=%0b rdData=%h, required 1 0 %h",
               n_done, busy, rdData, ref_rd);
    end
  endtask

  task automatic test_reset_mid_write();
    int n_done;
    logic [31:0] prev_m;
    prev_m = ref_mem[3];
    @(negedge clk);
    req = 1'b1; reqWrite = 1'b1; size = SZ_WORD; byteAddr = 7'd12; wrData = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (memWrite !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_write_pre: memWrite=%0b required 1", memWrite);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (memWrite !== 1'b0 || memRead !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_drop: memWrite=%0b memRead=%0b required 0 0", memWrite, memRead);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem[3] !== prev_m) begin
      failures++;
      $display("FAIL rst_no_write: mem3=%h required %h", mem[3], prev_m);
    end
    checks++;
    if ({busy, done, fault, memRead, memWrite, memAddr, rdData, memDataOut} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: busy=%0b done=%0b rdData=%h dout=%h addr=%0d, required all 0",
               busy, done, rdData, memDataOut, memAddr);
    end
    rst_n = 1'b1;
    ref_rd = 32'h0;
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      failures++;
      $display("FAIL rst_no_done: dones=%0d required 0", n_done);
    end
  endtask

  task automatic test_random();
    int lat, n_rd, n_wr, e_lat, e_rd, e_wr;
    logic [31:0] ww, ew, d;
    logic [4:0] aa;
    logic flt, ov, ef, w, sg;
    logic [1:0] sz;
    logic [6:0] a;
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 127));
      d  = $urandom;
      model(w, sz, sg, a, d, e_lat, e_rd, e_wr, ef, ew);
      run_access(w, sz, sg, a, d, lat, n_rd, n_wr, ww, aa, flt, ov);
      checks++;
      if (lat !== e_lat || n_rd !== e_rd || n_wr !== e_wr || flt !== ef || ov !== 1'b0) begin
        failures++;
        $display("FAIL rand_%0d_ctrl: lat=%0d rd=%0d wr=%0d fault=%0b ov=%0b, required %0d %0d %0d %0b 0 (w=%0b sz=%0d a=%0d)",
                 i, lat, n_rd, n_wr, flt, ov, e_lat, e_rd, e_wr, ef, w, sz, a);
      end
      checks++;
      if (rdData !== ref_rd) begin
        failures++;
        $display("FAIL rand_%0d_rdData: got %h required %h (w=%0b sz=%0d sg=%0b a=%0d)",
                 i, rdData, ref_rd, w, sz, sg, a);
      end
      if (!ef) begin
        checks++;
        if (aa !== a[6:2]) begin
          failures++;
          $display("FAIL rand_%0d_addr: got %0d required %0d", i, aa, a[6:2]);
        end
      end
      if (w && !ef) begin
        checks++;
        if (ww !== ew || mem[a[6:2]] !== ew) begin
          failures++;
          $display("FAIL rand_%0d_store: dout=%h mem=%h required %h (sz=%0d a=%0d d=%h)",
                   i, ww, mem[a[6:2]], ew, sz, a, d);
        end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_word_load();
    test_subword_loads();
    test_byte_store();
    test_faults();
    test_req_while_busy();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
